// File: rtl/div_issue_pkg.sv
// Shared encodings for the divider issue block: FSM states, divide op codes,
// divider handshake levels and the zero word.
package div_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [7:0]  EXE_DIV_OP           = 8'b0001_1010;
  localparam logic [7:0]  EXE_DIVU_OP          = 8'b0001_1011;
  localparam logic        DIV_START            = 1'b1;
  localparam logic        DIV_STOP             = 1'b0;
  localparam logic        DIV_RESULT_READY     = 1'b1;
  localparam logic        DIV_RESULT_NOT_READY = 1'b0;
  localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;

endpackage

// File: rtl/div_issue_hilo_reg.sv
// HI/LO architectural register pair; loads both halves together on we and
// holds them otherwise.
module hilo_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  import div_issue_pkg::*;

  logic [31:0] hi_q, lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= ZERO_WORD;
      lo_q <= ZERO_WORD;
    end else if (we) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/div_issue.sv
// Issues DIV/DIVU from EX to a multi-cycle divider, stalls the pipe, and writes HI/LO.
// Optional DIV_ZERO_SKIP_EN: a zero divisor bypasses the divider and leaves HI/LO alone.
module div_issue
  import div_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic [7:0]  alucontrol_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic [7:0]  div_alucontrol_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o
);

  state_e      state_q, state_d;
  logic [7:0]  alu_q, alu_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        start_q, start_d;
  logic        annul_q, annul_d;
  logic        we_q, we_d;
  logic        drain_cnt_q, drain_cnt_d;
  logic        hilo_wr;
  logic        zero_skip;

`ifdef DIV_ZERO_SKIP_EN
  assign zero_skip = (src_b_i == ZERO_WORD);
`else
  assign zero_skip = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    alu_d       = alu_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    start_d     = start_q;
    annul_d     = annul_q;
    we_d        = 1'b0;
    drain_cnt_d = drain_cnt_q;
    hilo_wr     = 1'b0;
    stall_o     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (div_req_i && !flush_i) begin
          stall_o = 1'b1;
          alu_d   = alucontrol_i;
          opa_d   = src_a_i;
          opb_d   = src_b_i;
          if (zero_skip) begin
            state_d = ST_DONE;
          end else begin
            start_d = DIV_START;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        // A kill from EX wins over a result arriving in the same cycle.
        if (flush_i) begin
          start_d     = DIV_STOP;
          annul_d     = 1'b1;
          drain_cnt_d = 1'b0;
          state_d     = ST_DRAIN;
        end else if (div_ready_i == DIV_RESULT_READY) begin
          hilo_wr = 1'b1;
          we_d    = 1'b1;
          start_d = DIV_STOP;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        stall_o     = div_req_i;
        drain_cnt_d = 1'b1;
        if (drain_cnt_q) begin
          annul_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_q       <= 8'd0;
      opa_q       <= ZERO_WORD;
      opb_q       <= ZERO_WORD;
      start_q     <= DIV_STOP;
      annul_q     <= 1'b0;
      we_q        <= 1'b0;
      drain_cnt_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      alu_q       <= alu_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      start_q     <= start_d;
      annul_q     <= annul_d;
      we_q        <= we_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  hilo_reg u_hilo_reg (
    .clk  (clk),
    .rst  (rst),
    .we   (hilo_wr),
    .hi_i (div_result_i[63:32]),
    .lo_i (div_result_i[31:0]),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

  assign div_start_o      = start_q;
  assign div_annul_o      = annul_q;
  assign div_alucontrol_o = alu_q;
  assign div_opdata1_o    = opa_q;
  assign div_opdata2_o    = opb_q;
  assign hilo_we_o        = we_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_issue.sv
// Bench for div_issue: plays the multi-cycle divider and the EX stage, and
// compares against HI/LO values derived from plain 64-bit arithmetic.
module tb_div_issue;

  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_req_i = 1'b0;
  logic [7:0]  alucontrol_i = 8'd0;
  logic [31:0] src_a_i = 32'd0;
  logic [31:0] src_b_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        div_start_o, div_annul_o;
  logic [7:0]  div_alucontrol_o;
  logic [31:0] div_opdata1_o, div_opdata2_o;
  logic        div_ready_i = 1'b0;
  logic [63:0] div_result_i = 64'd0;
  logic        stall_o, hilo_we_o, busy_o;
  logic [31:0] hi_o, lo_o;

  int          n_vec = 0;
  int          n_err = 0;
  int          we_cnt = 0;
  int          lat_cfg = 3;
  int          dcnt = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  div_issue dut (
    .clk              (clk),
    .rst              (rst),
    .div_req_i        (div_req_i),
    .alucontrol_i     (alucontrol_i),
    .src_a_i          (src_a_i),
    .src_b_i          (src_b_i),
    .flush_i          (flush_i),
    .div_start_o      (div_start_o),
    .div_annul_o      (div_annul_o),
    .div_alucontrol_o (div_alucontrol_o),
    .div_opdata1_o    (div_opdata1_o),
    .div_opdata2_o    (div_opdata2_o),
    .div_ready_i      (div_ready_i),
    .div_result_i     (div_result_i),
    .stall_o          (stall_o),
    .hilo_we_o        (hilo_we_o),
    .hi_o             (hi_o),
    .lo_o             (lo_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  // Quotient truncates toward zero, remainder takes the dividend's sign; x/0 -> (0,0).
  function automatic logic [63:0] ref_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (op == OP_DIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Divider model: counts cycles with start held and raises ready for one cycle after lat_cfg of them.
  always @(negedge clk) begin
    if (rst || !div_start_o || div_annul_o) begin
      dcnt        = 0;
      div_ready_i = 1'b0;
    end else begin
      dcnt = dcnt + 1;
      if (dcnt == lat_cfg) begin
        div_ready_i  = 1'b1;
        div_result_i = ref_div(div_alucontrol_o, div_opdata1_o, div_opdata2_o);
      end else begin
        div_ready_i = 1'b0;
      end
    end
  end

  always @(negedge clk) if (hilo_we_o === 1'b1) we_cnt = we_cnt + 1;

  // One full instruction: accept in IDLE, hold through BUSY, retire in DONE, back to IDLE.
  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input int lat);
    int          n;
    int          we0;
    int          exp_n;
    logic        skip;
    logic [63:0] r;
    lat_cfg = lat;
    we0     = we_cnt;
    skip    = 1'b0;
`ifdef DIV_ZERO_SKIP_EN
    skip = (b == 32'd0);
`endif
    exp_n = skip ? 0 : lat;
    div_req_i = 1'b1; flush_i = 1'b0; alucontrol_i = op; src_a_i = a; src_b_i = b;
    #1;
    n_vec++;
    if ({stall_o, busy_o, div_start_o, div_annul_o} !== 4'b1000) begin
      n_err++;
      $display("FAIL accept: stall/busy/start/annul=%b required 1000", {stall_o, busy_o, div_start_o, div_annul_o});
    end
    @(negedge clk); #1;
    n = 0;
    while (stall_o === 1'b1 && n < 300) begin
      n_vec++;
      if ({div_start_o, div_annul_o, div_alucontrol_o, div_opdata1_o, div_opdata2_o} !== {1'b1, 1'b0, op, a, b}) begin
        n_err++;
        $display("FAIL busy_hold: start=%b annul=%b alu=%h a=%h b=%h required start=1 annul=0 alu=%h a=%h b=%h",
                 div_start_o, div_annul_o, div_alucontrol_o, div_opdata1_o, div_opdata2_o, op, a, b);
      end
      @(negedge clk); #1;
      n++;
    end
    n_vec++;
    if (n != exp_n) begin
      n_err++;
      $display("FAIL stall_len: %0d stalled busy cycles, required %0d", n, exp_n);
    end
    if (!skip) begin
      r    = ref_div(op, a, b);
      m_hi = r[63:32];
      m_lo = r[31:0];
    end
    n_vec++;
    if ({stall_o, busy_o, div_start_o, div_annul_o, hilo_we_o} !== {4'b0100, ~skip}) begin
      n_err++;
      $display("FAIL done_state: stall/busy/start/annul/we=%b required %b",
               {stall_o, busy_o, div_start_o, div_annul_o, hilo_we_o}, {4'b0100, ~skip});
    end
    n_vec++;
    if ({hi_o, lo_o} !== {m_hi, m_lo}) begin
      n_err++;
      $display("FAIL hilo op=%h a=%h b=%h: hi=%h lo=%h required hi=%h lo=%h", op, a, b, hi_o, lo_o, m_hi, m_lo);
    end
    @(negedge clk);
    div_req_i = 1'b0;
    #1;
    n_vec++;
    if ({busy_o, div_start_o, hilo_we_o, stall_o} !== 4'b0000 || {hi_o, lo_o} !== {m_hi, m_lo}) begin
      n_err++;
      $display("FAIL idle_after: busy/start/we/stall=%b hi=%h lo=%h required 0000 hi=%h lo=%h",
               {busy_o, div_start_o, hilo_we_o, stall_o}, hi_o, lo_o, m_hi, m_lo);
    end
    n_vec++;
    if (we_cnt - we0 != (skip ? 0 : 1)) begin
      n_err++;
      $display("FAIL we_pulses: %0d pulses, required %0d", we_cnt - we0, skip ? 0 : 1);
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({div_start_o, div_annul_o, hilo_we_o, busy_o, stall_o} !== 5'b0 ||
        {hi_o, lo_o, div_opdata1_o, div_opdata2_o, div_alucontrol_o} !== 136'd0) begin
      n_err++;
      $display("FAIL reset: ctrl=%b hi=%h lo=%h a=%h b=%h alu=%h required all zero",
               {div_start_o, div_annul_o, hilo_we_o, busy_o, stall_o}, hi_o, lo_o,
               div_opdata1_o, div_opdata2_o, div_alucontrol_o);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_div(OP_DIVU, 32'd100, 32'd7, 5);
    do_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 3);
    do_div(OP_DIVU, 32'd5, 32'd0, 4);
    do_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFD, 1);
  endtask

  task automatic test_idle_flush();
    div_req_i = 1'b1; flush_i = 1'b1; alucontrol_i = OP_DIVU; src_a_i = 32'd77; src_b_i = 32'd3;
    #1;
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_flush_stall: stall=%b required 0", stall_o);
    end
    @(negedge clk); #1;
    n_vec++;
    if ({busy_o, div_start_o, hilo_we_o} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_flush_accept: busy/start/we=%b required 000", {busy_o, div_start_o, hilo_we_o});
    end
    div_req_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    int we0;
    we0 = we_cnt;
    lat_cfg = 40;
    div_req_i = 1'b1; flush_i = 1'b0; alucontrol_i = OP_DIVU; src_a_i = 32'd1000; src_b_i = 32'd3;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    n_vec++;
    if ({stall_o, busy_o, div_start_o} !== 3'b111) begin
      n_err++;
      $display("FAIL flush_pre: stall/busy/start=%b required 111", {stall_o, busy_o, div_start_o});
    end
    @(negedge clk);
    flush_i = 1'b0; div_req_i = 1'b1; src_a_i = 32'd9; src_b_i = 32'd3;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++;
      if ({div_annul_o, div_start_o, stall_o, busy_o, hilo_we_o} !== 5'b10110) begin
        n_err++;
        $display("FAIL drain_%0d: annul/start/stall/busy/we=%b required 10110", c,
                 {div_annul_o, div_start_o, stall_o, busy_o, hilo_we_o});
      end
      @(negedge clk);
    end
    n_vec++;
    if ({hi_o, lo_o} !== {m_hi, m_lo} || we_cnt != we0) begin
      n_err++;
      $display("FAIL flush_hilo: hi=%h lo=%h writes=%0d required hi=%h lo=%h writes=0",
               hi_o, lo_o, we_cnt - we0, m_hi, m_lo);
    end
    do_div(OP_DIVU, 32'd9, 32'd3, 2);
  endtask

  task automatic test_async_reset();
    lat_cfg = 30;
    div_req_i = 1'b1; flush_i = 1'b0; alucontrol_i = OP_DIVU; src_a_i = 32'd1234; src_b_i = 32'd5;
    repeat (3) @(negedge clk);
    div_req_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    n_vec++;
    if ({div_start_o, div_annul_o, hilo_we_o, busy_o, stall_o} !== 5'b0 ||
        {hi_o, lo_o, div_opdata1_o, div_opdata2_o, div_alucontrol_o} !== 136'd0) begin
      n_err++;
      $display("FAIL async_reset: ctrl=%b hi=%h lo=%h a=%h b=%h alu=%h required all zero",
               {div_start_o, div_annul_o, hilo_we_o, busy_o, stall_o}, hi_o, lo_o,
               div_opdata1_o, div_opdata2_o, div_alucontrol_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_div(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 6);
  endtask

  task automatic test_back_to_back();
    do_div(OP_DIV, 32'hFFFF_FF00, 32'd16, 2);
    do_div(OP_DIV, 32'd1000, 32'hFFFF_FFF9, 3);
    do_div(OP_DIV, 32'd45, 32'd6, 1);
  endtask

  task automatic test_random();
    logic [7:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 20);
        2:       b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      do_div(op, a, b, $urandom_range(1, 8));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle_flush();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_issue.md
DIV_ISSUE -- requirements
Module: div_issue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 Request-side ports SHALL be: div_req_i  in  1  EX holds DIV/DIVU; alucontrol_i  in  8  op code; src_a_i  in  32  dividend; src_b_i  in  32  divisor; flush_i  in  1  kill EX instruction.
REQ-003 Divider-side ports SHALL be: div_start_o  out  1; div_annul_o  out  1; div_alucontrol_o  out  8; div_opdata1_o  out  32; div_opdata2_o  out  32; div_ready_i  in  1; div_result_i  in  64  {remainder, quotient}.
REQ-004 Pipeline/HILO ports SHALL be: stall_o  out  1  freeze IF..EX; hilo_we_o  out  1  one-cycle write strobe; hi_o  out  32  remainder; lo_o  out  32  quotient; busy_o  out  1  state!=IDLE.

Function
REQ-005 The FSM SHALL have states IDLE, BUSY, DONE, DRAIN, with encodings defined in defines.vh.
REQ-006 IDLE: div_req_i=1 and flush_i=0 -> latch alucontrol_i, src_a_i, src_b_i; assert div_start_o from the next cycle; go to BUSY.
REQ-007 stall_o SHALL be combinational: 1 in IDLE when div_req_i=1 and flush_i=0; 1 throughout BUSY; 0 in DONE; in DRAIN, equal to div_req_i.
REQ-008 BUSY: div_start_o=1, div_annul_o=0; div_opdata1_o, div_opdata2_o and div_alucontrol_o SHALL be driven from the latched values, held stable until leaving BUSY (the divider samples the signed flag at completion).
REQ-009 BUSY with div_ready_i=1: register hi_o<=div_result_i[63:32] and lo_o<=div_result_i[31:0]; pulse hilo_we_o for exactly one cycle; deassert div_start_o (DivStop); go to DONE.
REQ-010 DONE SHALL last exactly one cycle, SHALL ignore div_req_i (the same instruction is still in EX), and SHALL then go to IDLE.
REQ-011 flush_i=1 in BUSY SHALL take priority over div_ready_i: no HI/LO write; div_start_o=0; div_annul_o=1; go to DRAIN.
REQ-012 DRAIN SHALL last exactly 2 cycles, with div_annul_o=1 and div_start_o=0 held, then go to IDLE; requests are not accepted in DRAIN.
REQ-013 flush_i=1 in IDLE SHALL block acceptance; flush_i in DONE or DRAIN SHALL have no effect.
REQ-014 A zero divisor SHALL be issued to the divider normally; HI/LO SHALL receive the divider's result (0,0).
REQ-015 hi_o and lo_o SHALL hold their value except on a hilo_we_o cycle.

Reset
REQ-016 rst=1 SHALL force state=IDLE, div_start_o=0, div_annul_o=0, hilo_we_o=0, hi_o=0, lo_o=0, latched operands=0, and alucontrol=0, asynchronously.
REQ-017 rst asserted mid-BUSY SHALL abandon the operation with no HI/LO write; the divider is reset by the same rst.

Configuration
REQ-018 With DIV_ZERO_SKIP_EN defined, an IDLE request with src_b_i=0 SHALL NOT start the divider; the block SHALL go directly to DONE with hilo_we_o=0 and HI/LO unchanged, and stall_o=1 for only the acceptance cycle.
REQ-019 Without DIV_ZERO_SKIP_EN, the behaviour SHALL be as in REQ-014.

Structure
REQ-020 defines.vh SHALL hold the FSM state encodings, EXE_DIV_OP/EXE_DIVU_OP, DivStart/DivStop, DivResultReady/NotReady, and ZeroWord.
REQ-021 The HI/LO storage SHALL be a sub-module hilo_reg (clk, rst, we, hi_i, lo_i, hi_o, lo_o); the FSM and muxing SHALL stay in div_issue.

Verification
REQ-022 DIVU 100/7 -> start held until ready; one hilo_we_o pulse; hi_o=2, lo_o=14; stall_o falls in DONE.
REQ-023 DIV -7/2 (0xFFFFFFF9, 2) -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD; div_alucontrol_o stays EXE_DIV_OP throughout BUSY.
REQ-024 flush_i 10 cycles after start -> annul_o=1 for 2 cycles; no hilo_we_o; HI/LO keep previous values; next DIVU 9/3 gives lo_o=3, hi_o=0.
REQ-025 DIVU 5/0 -> without the macro: HI=0, LO=0 written; with DIV_ZERO_SKIP_EN: start never asserts, no write, stall_o=1 for one cycle.
REQ-026 rst pulsed mid-BUSY -> all outputs 0 immediately (asynchronously); a following DIVU 0xFFFFFFFF/0x10 gives lo_o=0x0FFFFFFF, hi_o=0xF.
REQ-027 Back-to-back DIV requests -> the second is accepted only in IDLE after DONE; exactly one hilo_we_o pulse per instruction.
